// File: rtl/rptr_empty_level.sv
// Read-side pointer/empty/level control for a dual-clock FIFO (read clock domain).
// Optional sticky underflow flag enabled by defining RPTR_UNDERFLOW_EN.
module rptr_empty_level #(
  parameter int unsigned ADDR_WIDTH  = 8,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned AE_THRESH   = 1
) (
  input  logic                  rclk,
  input  logic                  rrst,
  input  logic                  rinc,
  input  logic [ADDR_WIDTH:0]   wptr_gray,
  output logic [ADDR_WIDTH-1:0] raddr,
  output logic [ADDR_WIDTH:0]   rptr,
  output logic                  rempty,
  output logic                  ralmost_empty,
  output logic [ADDR_WIDTH:0]   rlevel,
  output logic                  runderflow
);

  localparam int unsigned PW = ADDR_WIDTH + 1;
  localparam logic [PW-1:0] AE_LIMIT = PW'(AE_THRESH);

  logic [PW-1:0] sync_q [SYNC_STAGES];
  logic [PW-1:0] wq_gray;
  logic [PW-1:0] wq_bin;

  logic [PW-1:0] rbin_q, rbin_d;
  logic [PW-1:0] rptr_q, rptr_d;
  logic [PW-1:0] level_d, level_q;
  logic          rempty_q, rempty_d;
  logic          ralmost_q, ralmost_d;
  logic          rd_en;

  // Plain flop chain: nothing may sit between stages or metastability resolution suffers.
  always_ff @(posedge rclk or posedge rrst) begin
    if (rrst) begin
      for (int unsigned i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= wptr_gray;
      for (int unsigned i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  assign wq_gray = sync_q[SYNC_STAGES-1];

  always_comb begin
    wq_bin = '0;
    for (int unsigned i = 0; i < PW; i++) wq_bin[i] = ^(wq_gray >> i);
  end

  always_comb begin
    rd_en     = rinc & ~rempty_q;
    rbin_d    = rbin_q + {{ADDR_WIDTH{1'b0}}, rd_en};
    rptr_d    = (rbin_d >> 1) ^ rbin_d;
    // Level uses the post-read pointer so a read and a pointer update fold together.
    level_d   = wq_bin - rbin_d;
    rempty_d  = (rptr_d == wq_gray);
    ralmost_d = (level_d <= AE_LIMIT);
  end

  always_ff @(posedge rclk or posedge rrst) begin
    if (rrst) begin
      rbin_q    <= '0;
      rptr_q    <= '0;
      level_q   <= '0;
      rempty_q  <= 1'b1;
      ralmost_q <= 1'b1;
    end else begin
      rbin_q    <= rbin_d;
      rptr_q    <= rptr_d;
      level_q   <= level_d;
      rempty_q  <= rempty_d;
      ralmost_q <= ralmost_d;
    end
  end

`ifdef RPTR_UNDERFLOW_EN
  logic underflow_q, underflow_d;

  assign underflow_d = underflow_q | (rinc & rempty_q);

  always_ff @(posedge rclk or posedge rrst) begin
    if (rrst) underflow_q <= 1'b0;
    else      underflow_q <= underflow_d;
  end

  assign runderflow = underflow_q;
`else
  assign runderflow = 1'b0;
`endif

  assign raddr         = rbin_q[ADDR_WIDTH-1:0];
  assign rptr          = rptr_q;
  assign rempty        = rempty_q;
  assign ralmost_empty = ralmost_q;
  assign rlevel        = level_q;

endmodule

// File: tb/tb_rptr_empty_level.sv
// Directed self-checking bench for rptr_empty_level (ADDR_WIDTH=2, SYNC_STAGES=2, AE_THRESH=1).
module tb_rptr_empty_level;

  logic       rclk = 1'b0;
  logic       rrst;
  logic       rinc;
  logic [2:0] wptr_gray;
  logic [1:0] raddr;
  logic [2:0] rptr;
  logic       rempty;
  logic       ralmost_empty;
  logic [2:0] rlevel;
  logic       runderflow;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

`ifdef RPTR_UNDERFLOW_EN
  localparam logic UF_EXP = 1'b1;
`else
  localparam logic UF_EXP = 1'b0;
`endif

  rptr_empty_level #(
    .ADDR_WIDTH (2),
    .SYNC_STAGES(2),
    .AE_THRESH  (1)
  ) dut (
    .rclk         (rclk),
    .rrst         (rrst),
    .rinc         (rinc),
    .wptr_gray    (wptr_gray),
    .raddr        (raddr),
    .rptr         (rptr),
    .rempty       (rempty),
    .ralmost_empty(ralmost_empty),
    .rlevel       (rlevel),
    .runderflow   (runderflow)
  );

  always #5 rclk = ~rclk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge rclk);
    #1;
  endtask

  function automatic logic [2:0] gray3(input logic [2:0] b);
    return b ^ (b >> 1);
  endfunction

  task automatic check_reset_vals(input string tag);
    check_eq({tag, "_rempty"}, 32'(rempty), 32'd1);
    check_eq({tag, "_ae"}, 32'(ralmost_empty), 32'd1);
    check_eq({tag, "_rlevel"}, 32'(rlevel), 32'd0);
    check_eq({tag, "_rptr"}, 32'(rptr), 32'd0);
    check_eq({tag, "_raddr"}, 32'(raddr), 32'd0);
    check_eq({tag, "_uf"}, 32'(runderflow), 32'd0);
  endtask

  logic [2:0] rbin_exp;

  initial begin
    rrst      = 1'b1;
    rinc      = 1'b0;
    wptr_gray = 3'b000;
    repeat (2) tick();
    check_reset_vals("init");
    rrst = 1'b0;
    tick();
    check_eq("idle_rempty", 32'(rempty), 32'd1);

    // Latency: 000 -> 001 becomes visible on the 3rd edge.
    wptr_gray = 3'b001;
    tick();
    check_eq("lat_e1_rempty", 32'(rempty), 32'd1);
    tick();
    check_eq("lat_e2_rempty", 32'(rempty), 32'd1);
    check_eq("lat_e2_rlevel", 32'(rlevel), 32'd0);
    tick();
    check_eq("lat_e3_rempty", 32'(rempty), 32'd0);
    check_eq("lat_e3_rlevel", 32'(rlevel), 32'd1);
    check_eq("lat_e3_ae", 32'(ralmost_empty), 32'd1);
    wptr_gray = 3'b011;
    repeat (3) tick();
    check_eq("lvl2_rlevel", 32'(rlevel), 32'd2);
    check_eq("lvl2_ae", 32'(ralmost_empty), 32'd0);

    // Full level: write pointer binary 4.
    wptr_gray = 3'b110;
    repeat (3) tick();
    check_eq("full_rlevel", 32'(rlevel), 32'd4);
    rinc = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check_eq("full_raddr", 32'(raddr), 32'(i));
      tick();
      check_eq("full_rlevel_rd", 32'(rlevel), 32'(3 - i));
    end
    check_eq("full_rempty", 32'(rempty), 32'd1);
    check_eq("full_rptr", 32'(rptr), 32'b110);

    // Read while empty is blocked.
    tick();
    rinc = 1'b0;
    check_eq("uf_rptr", 32'(rptr), 32'b110);
    check_eq("uf_raddr", 32'(raddr), 32'd0);
    check_eq("uf_rempty", 32'(rempty), 32'd1);
    check_eq("uf_flag", 32'(runderflow), 32'(UF_EXP));

    // Wrap: write pointer held a full RAM ahead, read every cycle.
    wptr_gray = 3'b000;
    repeat (3) tick();
    check_eq("wrap_pre_rlevel", 32'(rlevel), 32'd4);
    rbin_exp = 3'd4;
    rinc = 1'b1;
    for (int k = 0; k < 10; k++) begin
      wptr_gray = gray3(rbin_exp + 3'd4);
      check_eq("wrap_raddr", 32'(raddr), 32'(rbin_exp[1:0]));
      tick();
      rbin_exp = rbin_exp + 3'd1;
      check_eq("wrap_rempty", 32'(rempty), 32'd0);
      check_eq("wrap_rptr", 32'(rptr), 32'(gray3(rbin_exp)));
      if (k == 3) check_eq("wrap_rptr_000", 32'(rptr), 32'b000);
    end
    rinc = 1'b0;
    check_eq("wrap_uf_sticky", 32'(runderflow), 32'(UF_EXP));

    // Settle at level 3, then reset asynchronously mid-cycle.
    repeat (3) tick();
    check_eq("pre_rst_rlevel", 32'(rlevel), 32'd3);
    #2 rrst = 1'b1;
    #1;
    check_reset_vals("async_rst");
    tick();
    rrst = 1'b0;
    wptr_gray = 3'b011;
    tick();
    tick();
    check_eq("post_rst_e2_rlevel", 32'(rlevel), 32'd0);
    tick();
    check_eq("post_rst_e3_rlevel", 32'(rlevel), 32'd2);
    check_eq("post_rst_rempty", 32'(rempty), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
